// File: rtl/data_mem_latency.sv
// Word-addressed data memory with a fixed access latency and a one-cycle mem_ready strobe.
// Serves one transaction at a time; the request is latched in IDLE and committed LATENCY edges later.
module data_mem_latency #(
  parameter int    DEPTH_LOG2 = 8,
  parameter int    LATENCY    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        busy,
  output logic        addr_error
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic                  wr;
    logic [DEPTH_LOG2+1:0] addr;
    logic [31:0]           data;
  } req_t;

  state_t          state;
  req_t            req;
  logic [CW-1:0]   cnt;
  logic [31:0]     mem [0:(1<<DEPTH_LOG2)-1];

  logic                  misaligned;
  logic                  commit;
  logic [DEPTH_LOG2-1:0] idx;

  // Address bits above the array wrap away by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:DEPTH_LOG2+2];

  assign misaligned = (req.addr[1:0] != 2'b00);
  assign idx        = req.addr[DEPTH_LOG2+1:2];
  assign commit     = (state == BUSY) && (cnt == '0);

  // Gated by reset so an abort on the commit edge never lands a write.
  always_ff @(posedge clk) begin
    if (reset && commit && req.wr && !misaligned)
      mem[idx] <= req.data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req        <= '0;
      read_data  <= '0;
      mem_ready  <= 1'b0;
      addr_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready  <= 1'b0;
          addr_error <= 1'b0;
          if (mem_read || mem_write) begin
            req.wr   <= mem_write;
            req.addr <= address[DEPTH_LOG2+1:0];
            req.data <= write_data;
            cnt      <= CW'(LATENCY - 1);
            state    <= BUSY;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state      <= DONE;
            mem_ready  <= 1'b1;
            addr_error <= misaligned;
            if (!req.wr)
              read_data <= misaligned ? 32'h0 : mem[idx];
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          mem_ready  <= 1'b0;
          addr_error <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          mem_ready  <= 1'b0;
          addr_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_latency.sv
// Directed bench: dut 0 runs LATENCY=4, dut 1 runs LATENCY=1; both share clk and reset.
module tb_data_mem_latency;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd, wr, rdy, bsy, aerr;
  logic [31:0] addr_t [2];
  logic [31:0] wd [2];
  logic [31:0] rdat [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  data_mem_latency #(.DEPTH_LOG2(8), .LATENCY(4)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
    .address(addr_t[0]), .write_data(wd[0]), .read_data(rdat[0]),
    .mem_ready(rdy[0]), .busy(bsy[0]), .addr_error(aerr[0])
  );

  data_mem_latency #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
    .address(addr_t[1]), .write_data(wd[1]), .read_data(rdat[1]),
    .mem_ready(rdy[1]), .busy(bsy[1]), .addr_error(aerr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Issue one request, hold it until mem_ready, then drop it; returns cycles from sample edge to ready.
  task automatic op(input int d, input string tag, input logic r, input logic w,
                    input logic [31:0] a, input logic [31:0] dat,
                    output logic [31:0] rd_o, output logic err_o, output int cyc);
    rd[d] = r; wr[d] = w; addr_t[d] = a; wd[d] = dat;
    @(posedge clk); #1;
    chk({tag, "_busy"}, 32'(bsy[d]), 32'd1);
    cyc = 0;
    while (!rdy[d] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd_o = rdat[d]; err_o = aerr[d];
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          c;
    logic [7:0]  mask;
    int          npulse;

    rd = '0; wr = '0;
    addr_t[0] = '0; addr_t[1] = '0; wd[0] = '0; wd[1] = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdat[0], 32'h0);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_busy",  32'(bsy[0]), 32'd0);
    chk("rst_aerr",  32'(aerr[0]), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Store then load at LATENCY=4
    op(0, "t1w", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, r, e, c);
    chk("t1w_lat", 32'(c), 32'd4);
    chk("t1w_rdata_unchanged", r, 32'h0);
    chk("t1w_aerr", 32'(e), 32'd0);
    op(0, "t1r", 1'b1, 1'b0, 32'h10, 32'h0, r, e, c);
    chk("t1r_lat", 32'(c), 32'd4);
    chk("t1r_data", r, 32'hDEADBEEF);

    // Read and write both high: write wins
    op(0, "t3w", 1'b1, 1'b1, 32'h8, 32'h12345678, r, e, c);
    chk("t3w_rdata_held", r, 32'hDEADBEEF);
    op(0, "t3r", 1'b1, 1'b0, 32'h8, 32'h0, r, e, c);
    chk("t3r_data", r, 32'h12345678);

    // Misaligned write is suppressed; 0x400 aliases word 0
    op(0, "t4a", 1'b0, 1'b1, 32'h0, 32'h11112222, r, e, c);
    op(0, "t4w", 1'b0, 1'b1, 32'h402, 32'h00000BAD, r, e, c);
    chk("t4w_aerr", 32'(e), 32'd1);
    chk("t4w_lat", 32'(c), 32'd4);
    op(0, "t4r", 1'b1, 1'b0, 32'h400, 32'h0, r, e, c);
    chk("t4r_data", r, 32'h11112222);
    chk("t4r_aerr", 32'(e), 32'd0);
    op(0, "t4m", 1'b1, 1'b0, 32'h401, 32'h0, r, e, c);
    chk("t4m_data", r, 32'h0);
    chk("t4m_aerr", 32'(e), 32'd1);

    op(0, "t5w", 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, r, e, c);
    op(0, "t5r", 1'b1, 1'b0, 32'h0, 32'h0, r, e, c);
    chk("t5r_data", r, 32'hCAFEF00D);

    // Reset on the commit edge aborts the write
    op(0, "t6a", 1'b0, 1'b1, 32'h20, 32'h00000055, r, e, c);
    wr[0] = 1'b1; addr_t[0] = 32'h20; wd[0] = 32'h00000099;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_pre_ready", 32'(rdy[0]), 32'd0);
    reset = 1'b0; wr[0] = 1'b0;
    @(posedge clk); #1;
    chk("t6_rdata", rdat[0], 32'h0);
    chk("t6_ready", 32'(rdy[0]), 32'd0);
    chk("t6_busy",  32'(bsy[0]), 32'd0);
    chk("t6_aerr",  32'(aerr[0]), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    op(0, "t6r", 1'b1, 1'b0, 32'h20, 32'h0, r, e, c);
    chk("t6r_data", r, 32'h00000055);

    // LATENCY=1, held read request across two transactions
    op(1, "t2a", 1'b0, 1'b1, 32'h0, 32'h0000000A, r, e, c);
    chk("t2a_lat", 32'(c), 32'd1);
    op(1, "t2b", 1'b0, 1'b1, 32'h4, 32'h0000000B, r, e, c);
    rd[1] = 1'b1; addr_t[1] = 32'h0;
    mask = '0; npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rdy[1]) begin
        mask[i] = 1'b1;
        npulse++;
        if (npulse == 1) begin
          chk("t2_data0", rdat[1], 32'h0000000A);
          addr_t[1] = 32'h4;
        end else if (npulse == 2) begin
          chk("t2_data1", rdat[1], 32'h0000000B);
          rd[1] = 1'b0;
        end
      end
    end
    chk("t2_pulse_mask", 32'(mask), 32'h12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
